// File: rtl/tvf_word_packer_if.sv
// Write-side group bus, SRAM word ports and read-side group stream
// for tvf_word_packer.
interface tvf_word_packer_if #(
    parameter int VEF_BIT    = 11,
    parameter int T_PER_WORD = 4,
    parameter int WCNT_BIT   = 10
);
    localparam int GROUP_BIT = 2 + 2 * (VEF_BIT - 1);
    localparam int SRAM_WORD = T_PER_WORD * GROUP_BIT;

    logic                 i_init;
    logic                 i_t_valid;
    logic [1:0]           i_t;
    logic [VEF_BIT-1:0]   i_v;
    logic [VEF_BIT-1:0]   i_f;
    logic                 i_flush;
    logic                 o_sram_send;
    logic [SRAM_WORD-1:0] o_send_data;
    logic [WCNT_BIT-1:0]  o_words_written;
    logic                 i_start_read;
    logic [WCNT_BIT-1:0]  i_read_words;
    logic                 o_sram_request;
    logic                 i_request_valid;
    logic [SRAM_WORD-1:0] i_request_data;
    logic                 o_valid;
    logic                 i_take;
    logic [1:0]           o_t;
    logic [VEF_BIT-1:0]   o_v;
    logic [VEF_BIT-1:0]   o_f;
    logic                 o_done;
    logic                 o_busy;

    modport slave (
        input  i_init, i_t_valid, i_t, i_v, i_f, i_flush,
        input  i_start_read, i_read_words,
        input  i_request_valid, i_request_data, i_take,
        output o_sram_send, o_send_data, o_words_written,
        output o_sram_request, o_valid, o_t, o_v, o_f,
        output o_done, o_busy
    );

    modport master (
        output i_init, i_t_valid, i_t, i_v, i_f, i_flush,
        output i_start_read, i_read_words,
        output i_request_valid, i_request_data, i_take,
        input  o_sram_send, o_send_data, o_words_written,
        input  o_sram_request, o_valid, o_t, o_v, o_f,
        input  o_done, o_busy
    );
endinterface

// File: rtl/tvf_word_packer.sv
// Packs (t, v, f) groups into SRAM words on the write side and
// unpacks SRAM words back into a group stream on the read side.
module tvf_word_packer #(
    parameter int VEF_BIT    = 11,
    parameter int T_PER_WORD = 4,
    parameter int WCNT_BIT   = 10
) (
    input logic             clk,
    input logic             rst,
    tvf_word_packer_if.slave bus
);
    localparam int SB        = VEF_BIT - 1;
    localparam int GROUP_BIT = 2 + 2 * SB;
    localparam int SRAM_WORD = T_PER_WORD * GROUP_BIT;
    localparam int PTR_BIT   = (T_PER_WORD > 1) ? $clog2(T_PER_WORD) : 1;
    localparam logic [PTR_BIT-1:0] LAST = PTR_BIT'(T_PER_WORD - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } rd_state_t;

    logic clr;
    assign clr = rst | bus.i_init;

    logic [PTR_BIT-1:0]   wr_ptr;
    logic [SRAM_WORD-1:0] wr_buf;
    logic [SRAM_WORD-1:0] wr_word;
    logic [GROUP_BIT-1:0] wr_group;
    logic                 wr_send;
    logic                 send_q;
    logic [SRAM_WORD-1:0] data_q;
    logic [WCNT_BIT-1:0]  words_q;

    assign wr_group = {bus.i_t, bus.i_v[SB-1:0], bus.i_f[SB-1:0]};

    // Slots past the pointer are always zero, so OR-ing in the new group
    // also yields the zero padding of a flushed partial word.
    always_comb begin
        wr_word = wr_buf;
        if (bus.i_t_valid) begin
            wr_word = wr_buf |
                ({wr_group, {(SRAM_WORD - GROUP_BIT){1'b0}}}
                 >> (wr_ptr * GROUP_BIT));
        end
    end

    assign wr_send = (bus.i_t_valid && wr_ptr == LAST) ||
                     (bus.i_flush && (bus.i_t_valid || wr_ptr != '0));

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr  <= '0;
            wr_buf  <= '0;
            send_q  <= 1'b0;
            data_q  <= '0;
            words_q <= '0;
        end else begin
            send_q <= wr_send;
            if (wr_send) begin
                wr_ptr <= '0;
                wr_buf <= '0;
                data_q <= wr_word;
                if (~&words_q) words_q <= words_q + 1'b1;
            end else if (bus.i_t_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
                wr_buf <= wr_word;
            end
        end
    end

    rd_state_t            state;
    rd_state_t            state_d;
    logic [WCNT_BIT-1:0]  rd_left;
    logic [PTR_BIT-1:0]   rd_slot;
    logic [SRAM_WORD-1:0] rd_buf;
    logic [SRAM_WORD-1:0] rd_shift;
    logic [GROUP_BIT-1:0] rd_group;
    logic                 req_q;
    logic                 done_q;
    logic                 take;
    logic                 last_take;
    logic                 zero_read;

    assign take      = (state == DRAIN) && bus.i_take;
    assign last_take = take && (rd_slot == LAST);
    assign zero_read = (state == IDLE) && bus.i_start_read &&
                       (bus.i_read_words == '0);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (bus.i_start_read && bus.i_read_words != '0)
                    state_d = REQ;
            end
            REQ: state_d = WAIT;
            WAIT: begin
                if (bus.i_request_valid) state_d = DRAIN;
            end
            DRAIN: begin
                if (last_take) state_d = (rd_left != '0) ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            rd_left <= '0;
            rd_slot <= '0;
            rd_buf  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_d;
            req_q  <= (state == REQ);
            done_q <= zero_read || (last_take && rd_left == '0);
            if (state == IDLE && bus.i_start_read)
                rd_left <= bus.i_read_words;
            if (state == REQ)
                rd_left <= rd_left - 1'b1;
            if (state == WAIT && bus.i_request_valid) begin
                rd_buf  <= bus.i_request_data;
                rd_slot <= '0;
            end
            if (take)
                rd_slot <= (rd_slot == LAST) ? '0 : rd_slot + 1'b1;
        end
    end

    assign rd_shift = rd_buf << (rd_slot * GROUP_BIT);
    assign rd_group = rd_shift[SRAM_WORD-1 -: GROUP_BIT];

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.i_v[SB], bus.i_f[SB],
                           rd_shift[SRAM_WORD-GROUP_BIT-1:0]};

    assign bus.o_sram_send     = send_q;
    assign bus.o_send_data     = data_q;
    assign bus.o_words_written = words_q;
    assign bus.o_sram_request  = req_q;
    assign bus.o_valid         = (state == DRAIN);
    assign bus.o_t             = rd_group[GROUP_BIT-1 -: 2];
    assign bus.o_v             = {1'b0, rd_group[2*SB-1 -: SB]};
    assign bus.o_f             = {1'b0, rd_group[SB-1:0]};
    assign bus.o_done          = done_q;
    assign bus.o_busy          = (state != IDLE);
endmodule

// File: tb/tb_tvf_word_packer.sv
// Randomised and directed bench for tvf_word_packer against a
// queue-based model of packing and unpacking.
module tb_tvf_word_packer;
    localparam int VEF_BIT    = 11;
    localparam int T_PER_WORD = 4;
    localparam int WCNT_BIT   = 10;
    localparam int SB         = VEF_BIT - 1;
    localparam int GB         = 2 + 2 * SB;
    localparam int SW         = T_PER_WORD * GB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tvf_word_packer_if #(
        .VEF_BIT(VEF_BIT), .T_PER_WORD(T_PER_WORD), .WCNT_BIT(WCNT_BIT)
    ) bus ();

    tvf_word_packer #(
        .VEF_BIT(VEF_BIT), .T_PER_WORD(T_PER_WORD), .WCNT_BIT(WCNT_BIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [SW-1:0] act,
                       input logic [SW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Model state
    logic [GB-1:0]       grp_q[$];
    logic [GB-1:0]       exp_grp[$];
    logic [SW-1:0]       sent_q[$];
    logic [SW-1:0]       mem[16];
    logic [SW-1:0]       exp_data = '0;
    logic [SW-1:0]       tmp;
    logic [WCNT_BIT-1:0] exp_wcnt = '0;
    bit                  exp_send = 0;
    bit                  exp_done = 0;
    bit                  exp_busy = 0;
    bit                  outstanding = 0;
    bit                  idle;
    int                  avail = 0;
    int                  reqs = 0;
    int                  rd_n = 0;
    int                  rd_base = 0;
    int                  rsp_idx = 0;
    int                  resp_delay = 0;
    int                  take_pct = 100;
    int                  done_cnt = 0;

    always @(posedge clk) begin
        if (rst || bus.i_init) begin
            grp_q.delete();
            exp_grp.delete();
            exp_send = 0;
            exp_data = '0;
            exp_wcnt = '0;
            exp_done = 0;
            exp_busy = 0;
            avail = 0;
            outstanding = 0;
        end else begin
            exp_send = 0;
            if (bus.i_t_valid)
                grp_q.push_back({bus.i_t, bus.i_v[SB-1:0], bus.i_f[SB-1:0]});
            if (grp_q.size() == T_PER_WORD ||
                (bus.i_flush && grp_q.size() > 0)) begin
                exp_data = '0;
                foreach (grp_q[k]) exp_data[SW-1-k*GB -: GB] = grp_q[k];
                exp_send = 1;
                if (exp_wcnt != '1) exp_wcnt = exp_wcnt + 1'b1;
                grp_q.delete();
            end
            exp_done = 0;
            idle = !exp_busy;
            if (bus.i_request_valid && outstanding) begin
                outstanding = 0;
                avail = T_PER_WORD;
            end else if (bus.i_take && avail > 0) begin
                avail--;
                void'(exp_grp.pop_front());
                if (exp_grp.size() == 0) begin
                    exp_done = 1;
                    exp_busy = 0;
                end
            end
            if (idle && bus.i_start_read) begin
                rd_n = int'(bus.i_read_words);
                reqs = 0;
                rsp_idx = 0;
                if (rd_n == 0) exp_done = 1;
                else begin
                    exp_busy = 1;
                    for (int w = 0; w < rd_n; w++) begin
                        tmp = mem[(rd_base + w) % 16];
                        for (int s = 0; s < T_PER_WORD; s++)
                            exp_grp.push_back(tmp[SW-1-s*GB -: GB]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("o_sram_send", SW'(bus.o_sram_send), SW'(exp_send));
        chk("o_send_data", bus.o_send_data, exp_data);
        chk("o_words_written", SW'(bus.o_words_written), SW'(exp_wcnt));
        chk("o_valid", SW'(bus.o_valid), SW'(avail > 0));
        if (avail > 0 && exp_grp.size() > 0) begin
            tmp = SW'(exp_grp[0]);
            chk("group", SW'({bus.o_t, bus.o_v, bus.o_f}),
                SW'({tmp[GB-1 -: 2], 1'b0, tmp[2*SB-1 -: SB],
                     1'b0, tmp[SB-1:0]}));
        end
        chk("o_done", SW'(bus.o_done), SW'(exp_done));
        chk("o_busy", SW'(bus.o_busy), SW'(exp_busy));
        chk("request_legal",
            SW'(bus.o_sram_request & !(exp_busy && avail == 0 && !outstanding)),
            '0);
        if (bus.o_sram_request) begin
            reqs++;
            outstanding = 1;
        end
        if (bus.o_sram_send) sent_q.push_back(bus.o_send_data);
        if (bus.o_done) done_cnt++;
        if (exp_done) chk("req_count", SW'(reqs), SW'(rd_n));
    end

    // SRAM responder
    initial begin
        int d;
        bus.i_request_valid = 1'b0;
        bus.i_request_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.o_sram_request) begin
                d = (resp_delay > 0) ? resp_delay : int'($urandom_range(1, 4));
                repeat (d) @(posedge clk);
                #1;
                bus.i_request_valid = 1'b1;
                bus.i_request_data  = mem[(rd_base + rsp_idx) % 16];
                rsp_idx++;
                @(posedge clk);
                #1;
                bus.i_request_valid = 1'b0;
                bus.i_request_data  = SW'({$urandom, $urandom, $urandom});
            end
        end
    end

    // Consumer
    initial begin
        bus.i_take = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_take = ($urandom_range(0, 99) < take_pct);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] t, input int v, input int f,
                       input bit fl);
        bus.i_t_valid = 1'b1;
        bus.i_t       = t;
        bus.i_v       = VEF_BIT'(v);
        bus.i_f       = VEF_BIT'(f);
        bus.i_flush   = fl;
        cyc();
        bus.i_t_valid = 1'b0;
        bus.i_flush   = 1'b0;
    endtask

    task automatic start_read(input int base, input int words);
        rd_base = base;
        bus.i_read_words = WCNT_BIT'(words);
        bus.i_start_read = 1'b1;
        cyc();
        bus.i_start_read = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (exp_busy && n < 400) begin
            cyc();
            n++;
        end
        chk(name, SW'(exp_busy), '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [SW-1:0] w;
        int n;
        int d0;
        int r0;
        bus.i_init = 1'b0;
        bus.i_t_valid = 1'b0;
        bus.i_t = '0;
        bus.i_v = '0;
        bus.i_f = '0;
        bus.i_flush = 1'b0;
        bus.i_start_read = 1'b0;
        bus.i_read_words = '0;
        for (int i = 0; i < 16; i++) mem[i] = SW'({$urandom, $urandom, $urandom});
        w = mem[0];
        w[SW-1 -: GB] = {2'd1, 10'd5, 10'd7};
        mem[0] = w;
        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_words", SW'(bus.o_words_written), '0);
        chk("rst_busy", SW'(bus.o_busy), '0);
        chk("rst_group", SW'({bus.o_t, bus.o_v, bus.o_f}), '0);

        // Eight groups give two full words
        sent_q.delete();
        for (int k = 0; k < 8; k++) put(2'(k % 4), k, 2 * k, 0);
        cyc();
        cyc();
        chk("t1_sends", SW'(sent_q.size()), SW'(2));
        w = sent_q[0];
        chk("t1_w0_slot0", SW'(w[SW-1 -: GB]), '0);
        chk("t1_w0_slot3", SW'(w[GB-1:0]), SW'({2'd3, 10'd3, 10'd6}));
        chk("t1_words", SW'(bus.o_words_written), SW'(2));

        // Five groups then flush
        sent_q.delete();
        for (int k = 0; k < 5; k++) put(2'(k % 4), 100 + k, 200 + k, 0);
        bus.i_flush = 1'b1;
        cyc();
        bus.i_flush = 1'b0;
        cyc();
        cyc();
        chk("t2_sends", SW'(sent_q.size()), SW'(2));
        w = sent_q[1];
        chk("t2_partial", w, {2'd0, 10'd104, 10'd204, 66'd0});
        bus.i_flush = 1'b1;
        cyc();
        bus.i_flush = 1'b0;
        cyc();
        cyc();
        chk("t2_empty_flush", SW'(sent_q.size()), SW'(2));
        chk("t2_words", SW'(bus.o_words_written), SW'(4));

        // Flush on the filling group
        sent_q.delete();
        put(2'd1, 1, 1, 0);
        put(2'd2, 2, 2, 0);
        put(2'd3, 3, 3, 0);
        put(2'd0, 4, 4, 1);
        repeat (3) cyc();
        chk("t3_sends", SW'(sent_q.size()), SW'(1));
        w = sent_q[0];
        chk("t3_word", w, {2'd1, 10'd1, 10'd1, 2'd2, 10'd2, 10'd2,
                           2'd3, 10'd3, 10'd3, 2'd0, 10'd4, 10'd4});

        // Two-word read, 3-cycle SRAM latency
        take_pct = 100;
        resp_delay = 3;
        d0 = done_cnt;
        start_read(0, 2);
        n = 0;
        while (!bus.o_valid && n < 40) begin
            cyc();
            n++;
        end
        chk("t4_first_valid", SW'(bus.o_valid), SW'(1));
        chk("t4_first_t", SW'(bus.o_t), SW'(1));
        chk("t4_first_v", SW'(bus.o_v), SW'(5));
        chk("t4_first_f", SW'(bus.o_f), SW'(7));
        wait_idle("t4_idle");
        cyc();
        chk("t4_done_once", SW'(done_cnt - d0), SW'(1));
        chk("t4_busy", SW'(bus.o_busy), '0);

        // Consumer stalls inside a word
        take_pct = 0;
        resp_delay = 2;
        start_read(2, 1);
        n = 0;
        while (!bus.o_valid && n < 40) begin
            cyc();
            n++;
        end
        r0 = reqs;
        repeat (5) cyc();
        chk("t5_hold_valid", SW'(bus.o_valid), SW'(1));
        chk("t5_no_request", SW'(reqs - r0), '0);
        take_pct = 100;
        wait_idle("t5_idle");

        // Clear while waiting on SRAM with a half-built word
        resp_delay = 8;
        start_read(3, 1);
        n = 0;
        while (reqs == 0 && n < 40) begin
            cyc();
            n++;
        end
        chk("t6_requested", SW'(reqs), SW'(1));
        put(2'd3, 9, 9, 0);
        put(2'd3, 8, 8, 0);
        bus.i_init = 1'b1;
        cyc();
        bus.i_init = 1'b0;
        chk("t6_busy", SW'(bus.o_busy), '0);
        chk("t6_words", SW'(bus.o_words_written), '0);
        repeat (10) cyc();
        chk("t6_late_response", SW'(bus.o_valid), '0);
        sent_q.delete();
        put(2'd2, 11, 22, 0);
        put(2'd1, 33, 44, 0);
        put(2'd3, 55, 66, 0);
        put(2'd0, 77, 88, 0);
        cyc();
        cyc();
        chk("t6_sends", SW'(sent_q.size()), SW'(1));
        w = sent_q[0];
        chk("t6_word", w, {2'd2, 10'd11, 10'd22, 2'd1, 10'd33, 10'd44,
                           2'd3, 10'd55, 10'd66, 2'd0, 10'd77, 10'd88});
        chk("t6_words_after", SW'(bus.o_words_written), SW'(1));

        // Random traffic on both sides at once
        resp_delay = 0;
        take_pct = 60;
        for (int i = 0; i < 600; i++) begin
            bus.i_t_valid = ($urandom_range(0, 2) != 0);
            bus.i_t = 2'($urandom);
            bus.i_v = VEF_BIT'($urandom);
            bus.i_f = VEF_BIT'($urandom);
            bus.i_flush = ($urandom_range(0, 15) == 0);
            bus.i_start_read = !exp_busy && ($urandom_range(0, 7) == 0);
            bus.i_read_words = WCNT_BIT'($urandom_range(0, 3));
            if (bus.i_start_read) rd_base = int'($urandom_range(0, 15));
            cyc();
        end
        bus.i_t_valid = 1'b0;
        bus.i_start_read = 1'b0;
        bus.i_flush = 1'b1;
        cyc();
        bus.i_flush = 1'b0;
        take_pct = 100;
        wait_idle("rand_idle");
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
